// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite bus bundle between the command master and a slave.
// Five channels: AW, W, B, AR, R.
interface axi4_lite_master_if;
    logic        awvalid;
    logic [31:0] awaddr;
    logic        awready;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;
    logic        arvalid;
    logic [31:0] araddr;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rready;

    modport master (
        output awvalid, awaddr,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr,
        input  arready,
        input  rvalid, rdata, rresp,
        output rready
    );

    modport slave (
        input  awvalid, awaddr,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr,
        output arready,
        output rvalid, rdata, rresp,
        input  rready
    );
endinterface

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master bridging a cmd/rsp port to the bus.
// Optional watchdog compiled in with AXI_MASTER_TIMEOUT_EN.
module axi4_lite_master #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    axi4_lite_master_if.master axi
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        READ,
        RDATA,
        RESP
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        wr_q;
    logic        aw_done_q;
    logic        w_done_q;

    logic accept;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;
    logic timeout;
    logic to_fire;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // Every valid/ready is a pure function of registered state.
    always_comb begin
        cmd_ready   = (state_q == IDLE);
        rsp_valid   = (state_q == RESP);
        axi.awvalid = (state_q == WRITE) && !aw_done_q;
        axi.wvalid  = (state_q == WRITE) && !w_done_q;
        axi.bready  = (state_q == WRESP);
        axi.arvalid = (state_q == READ);
        axi.rready  = (state_q == RDATA);
        axi.awaddr  = addr_q;
        axi.araddr  = addr_q;
        axi.wdata   = wdata_q;
        axi.wstrb   = wstrb_q;
    end

    assign accept = cmd_valid && cmd_ready;
    assign aw_hs  = axi.awvalid && axi.awready;
    assign w_hs   = axi.wvalid && axi.wready;
    assign b_hs   = axi.bvalid && axi.bready;
    assign ar_hs  = axi.arvalid && axi.arready;
    assign r_hs   = axi.rvalid && axi.rready;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic          busy;

    assign busy = (state_q == WRITE) || (state_q == WRESP) ||
                  (state_q == READ)  || (state_q == RDATA);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if (busy) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout = busy && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A handshake landing on the watchdog cycle wins over the timeout.
    always_comb begin
        state_d = state_q;
        to_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = WRESP;
                end else if (timeout) begin
                    state_d = RESP;
                    to_fire = 1'b1;
                end
            end
            WRESP: begin
                if (b_hs) begin
                    state_d = RESP;
                end else if (timeout) begin
                    state_d = RESP;
                    to_fire = 1'b1;
                end
            end
            READ: begin
                if (ar_hs) begin
                    state_d = RDATA;
                end else if (timeout) begin
                    state_d = RESP;
                    to_fire = 1'b1;
                end
            end
            RDATA: begin
                if (r_hs) begin
                    state_d = RESP;
                end else if (timeout) begin
                    state_d = RESP;
                    to_fire = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wr_q      <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
        end else begin
            if (accept) begin
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                wstrb_q   <= cmd_wstrb;
                wr_q      <= cmd_write;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs)  w_done_q  <= 1'b1;
            end
            if (b_hs) begin
                rsp_write <= 1'b1;
                rsp_rdata <= '0;
                rsp_resp  <= axi.bresp;
            end
            if (r_hs) begin
                rsp_write <= 1'b0;
                rsp_rdata <= axi.rdata;
                rsp_resp  <= axi.rresp;
            end
            if (to_fire) begin
                rsp_write <= wr_q;
                rsp_rdata <= '0;
                rsp_resp  <= 2'b11;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master against a small AXI4-Lite slave model.
// Slave ready latencies and read stalls are set per step.
module tb_axi4_lite_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    axi4_lite_master_if axi ();

    axi4_lite_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .axi       (axi)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // slave model
    logic [31:0] mem [0:7];
    int          aw_lat = 0;
    int          w_lat = 0;
    bit          r_stall = 1'b0;
    bit          ar_block = 1'b0;
    int          awc;
    int          wc;
    logic        aw_got;
    logic        w_got;
    logic [31:0] aw_a;
    logic [31:0] w_d;
    logic [3:0]  w_s;

    assign axi.awready = axi.awvalid && (awc >= aw_lat);
    assign axi.wready  = axi.wvalid && (wc >= w_lat);
    assign axi.arready = axi.arvalid && !ar_block;

    wire        s_aw_hs = axi.awvalid && axi.awready;
    wire        s_w_hs  = axi.wvalid && axi.wready;
    wire        s_ar_hs = axi.arvalid && axi.arready;
    wire        s_both  = (aw_got || s_aw_hs) && (w_got || s_w_hs);
    wire [31:0] s_addr  = aw_got ? aw_a : axi.awaddr;
    wire [31:0] s_data  = w_got ? w_d : axi.wdata;
    wire [3:0]  s_strb  = w_got ? w_s : axi.wstrb;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            awc        <= 0;
            wc         <= 0;
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            aw_a       <= '0;
            w_d        <= '0;
            w_s        <= '0;
            axi.bvalid <= 1'b0;
            axi.bresp  <= 2'b00;
            axi.rvalid <= 1'b0;
            axi.rdata  <= '0;
            axi.rresp  <= 2'b00;
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else begin
            if (s_aw_hs) begin
                aw_got <= 1'b1;
                aw_a   <= axi.awaddr;
                awc    <= 0;
            end else if (axi.awvalid) begin
                awc <= awc + 1;
            end
            if (s_w_hs) begin
                w_got <= 1'b1;
                w_d   <= axi.wdata;
                w_s   <= axi.wstrb;
                wc    <= 0;
            end else if (axi.wvalid) begin
                wc <= wc + 1;
            end
            if (s_both) begin
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
                axi.bvalid <= 1'b1;
                axi.bresp  <= 2'b00;
                for (int i = 0; i < 4; i++)
                    if (s_strb[i])
                        mem[s_addr[4:2]][8*i +: 8] <= s_data[8*i +: 8];
            end
            if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
            if (s_ar_hs && !r_stall) begin
                axi.rvalid <= 1'b1;
                axi.rdata  <= mem[axi.araddr[4:2]];
                axi.rresp  <= 2'b00;
            end
            if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
        end
    end

    // bus monitor
    int          b_cnt = 0;
    int          rsp_cnt = 0;
    int          w_first = 0;
    int          aw_bad = 0;
    logic [31:0] aw_exp = '0;

    always @(posedge clk) begin
        if (axi.bvalid && axi.bready) b_cnt <= b_cnt + 1;
        if (rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;
        if (axi.awvalid && !axi.wvalid) w_first <= w_first + 1;
        if (axi.awvalid && axi.awaddr !== aw_exp) aw_bad <= aw_bad + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // called at a negedge; returns with rsp_valid seen (or budget spent)
    task automatic send(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output int lat);
        int k;
        aw_exp    = a;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 2;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    int lat;
    int b0;
    int r0;
    int wf0;
    int ab0;

    initial begin
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_valids", 32'({axi.awvalid, axi.wvalid, axi.bready,
                               axi.arvalid, axi.rready, rsp_valid}), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_resp", 32'(rsp_resp), 32'd0);
        chk("rst_awaddr", axi.awaddr, 32'h0);
        chk("rst_wstrb", 32'(axi.wstrb), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        b0 = b_cnt;
        send(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, lat);
        chk("wr_latency", 32'(lat), 32'd4);
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_rsp_write", 32'(rsp_write), 32'd1);
        chk("wr_rsp_resp", 32'(rsp_resp), 32'd0);
        chk("wr_rsp_rdata", rsp_rdata, 32'h0);
        chk("wr_mem4", mem[4], 32'hDEAD_BEEF);
        ack();
        chk("wr_b_count", 32'(b_cnt - b0), 32'd1);
        chk("b2b_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("b2b_rsp_valid", 32'(rsp_valid), 32'd0);

        send(1'b0, 32'h10, 32'h0, 4'h0, lat);
        chk("rd_latency", 32'(lat), 32'd4);
        chk("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("rd_rsp_resp", 32'(rsp_resp), 32'd0);
        chk("rd_rsp_write", 32'(rsp_write), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        ack();

        send(1'b1, 32'h14, 32'h1122_3344, 4'h5, lat);
        ack();
        send(1'b0, 32'h14, 32'h0, 4'h0, lat);
        chk("strb_rdata", rsp_rdata, 32'h0022_0044);
        ack();

        aw_lat = 3;
        b0  = b_cnt;
        r0  = rsp_cnt;
        wf0 = w_first;
        ab0 = aw_bad;
        send(1'b1, 32'h08, 32'hCAFE_0001, 4'hF, lat);
        chk("wfirst_latency", 32'(lat), 32'd7);
        chk("wfirst_rsp_write", 32'(rsp_write), 32'd1);
        ack();
        chk("wfirst_aw_only_cycles", 32'(w_first - wf0), 32'd3);
        chk("wfirst_aw_addr_stable", 32'(aw_bad - ab0), 32'd0);
        chk("wfirst_b_count", 32'(b_cnt - b0), 32'd1);
        chk("wfirst_rsp_count", 32'(rsp_cnt - r0), 32'd1);
        aw_lat = 0;

        w_lat = 2;
        send(1'b1, 32'h0C, 32'h0BAD_F00D, 4'hF, lat);
        chk("awfirst_latency", 32'(lat), 32'd6);
        ack();
        w_lat = 0;
        send(1'b0, 32'h0C, 32'h0, 4'h0, lat);
        chk("awfirst_rdata", rsp_rdata, 32'h0BAD_F00D);
        ack();

        r_stall   = 1'b1;
        r0        = rsp_cnt;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h10;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rdata_rready", 32'(axi.rready), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_valids", 32'({axi.awvalid, axi.wvalid, axi.bready,
                                   axi.arvalid, axi.rready, rsp_valid}),
            32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        r_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
        end
        chk("rst_mid_rsp_count", 32'(rsp_cnt - r0), 32'd0);
        send(1'b0, 32'h0, 32'h0, 4'h0, lat);
        chk("post_rst_latency", 32'(lat), 32'd4);
        chk("post_rst_rdata", rsp_rdata, 32'h0);
        ack();

`ifdef AXI_MASTER_TIMEOUT_EN
        ar_block = 1'b1;
        send(1'b0, 32'h20, 32'h0, 4'h0, lat);
        chk("to_latency", 32'(lat), 32'd18);
        chk("to_arvalid", 32'(axi.arvalid), 32'd0);
        chk("to_rsp_resp", 32'(rsp_resp), 32'd3);
        chk("to_rsp_rdata", rsp_rdata, 32'h0);
        ack();
        ar_block = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
